// File: rtl/cpu_pkg.sv
// Shared CPU constants and the IF/ID pipeline payload type.
// The fetch address-error check is enabled by defining FETCH_EXC_EN.
package cpu_pkg;

  localparam logic [31:0] PC_RESET_ADDR = 32'h0000_3000;
  localparam int          IM_WORDS      = 4096;
  localparam logic [31:0] NOP_INSTR     = 32'h0000_0000;
  localparam logic [4:0]  EXC_NONE      = 5'd0;
  localparam logic [4:0]  EXC_ADEL      = 5'd4;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc8;
    logic        valid;
    logic [4:0]  excCode;
  } ifid_t;

  // A bubble is a fully zeroed register, so reset and flush share it
  localparam ifid_t IFID_BUBBLE = '{
    instr:   NOP_INSTR,
    pc:      32'h0,
    pc8:     32'h0,
    valid:   1'b0,
    excCode: EXC_NONE
  };

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: reset and flush insert a bubble, stall holds,
// otherwise the fetched payload is captured.
module ifid_reg
  import cpu_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  i_flush,
  input  logic  i_stall,
  input  ifid_t i_load,
  output ifid_t o_ifid
);

  ifid_t r_ifid;

  // Flush wins over stall so a squashed slot never survives a hazard hold
  always_ff @(posedge clk) begin
    if (reset || i_flush) begin
      r_ifid <= IFID_BUBBLE;
    end else if (!i_stall) begin
      r_ifid <= i_load;
    end
  end

  assign o_ifid = r_ifid;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch: PC register, next-PC selection, IF/ID capture and fetch counter.
// Define FETCH_EXC_EN to raise AdEL for misaligned or out-of-text-segment PCs.
module if_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] PC_RESET = PC_RESET_ADDR,
  parameter int          IM_DEPTH = IM_WORDS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic [31:0] im_instr,
  output logic [31:0] im_addr,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc8,
  output logic        id_valid,
  output logic [4:0]  id_exc_code,
  output logic [31:0] fetch_cnt
);

  logic [31:0] r_pc;
  logic [31:0] r_fetchCnt;
  logic [31:0] w_pcPlus4;
  logic [31:0] w_pcPlus8;
  logic        w_load;
  ifid_t       w_loadData;
  ifid_t       w_ifid;

  if (IM_DEPTH < 1) begin : g_badDepth
    $error("if_fetch_unit: IM_DEPTH must be at least one word");
  end

  assign w_pcPlus4 = r_pc + 32'd4;
  assign w_pcPlus8 = r_pc + 32'd8;
  assign w_load    = !flush && !stall;
  assign im_addr   = r_pc;

`ifdef FETCH_EXC_EN
  localparam logic [31:0] PC_LAST = PC_RESET + 32'(4 * IM_DEPTH) - 32'd1;
  logic w_adel;

  assign w_adel = (r_pc[1:0] != 2'b00) || (r_pc < PC_RESET) || (r_pc > PC_LAST);

  // A faulting fetch still occupies a valid slot so the exception unit sees it
  always_comb begin
    w_loadData         = IFID_BUBBLE;
    w_loadData.instr   = w_adel ? NOP_INSTR : im_instr;
    w_loadData.pc      = r_pc;
    w_loadData.pc8     = w_pcPlus8;
    w_loadData.valid   = 1'b1;
    w_loadData.excCode = w_adel ? EXC_ADEL : EXC_NONE;
  end
`else
  always_comb begin
    w_loadData         = IFID_BUBBLE;
    w_loadData.instr   = im_instr;
    w_loadData.pc      = r_pc;
    w_loadData.pc8     = w_pcPlus8;
    w_loadData.valid   = 1'b1;
    w_loadData.excCode = EXC_NONE;
  end
`endif

  // Redirect is dropped while stalled; the NPC logic keeps it asserted
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc <= PC_RESET;
    end else if (!stall) begin
      r_pc <= redirect ? redirect_pc : w_pcPlus4;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetchCnt <= 32'd0;
    end else if (w_load) begin
      r_fetchCnt <= r_fetchCnt + 32'd1;
    end
  end

  ifid_reg u_ifidReg (
    .clk     (clk),
    .reset   (reset),
    .i_flush (flush),
    .i_stall (stall),
    .i_load  (w_loadData),
    .o_ifid  (w_ifid)
  );

  assign id_instr    = w_ifid.instr;
  assign id_pc       = w_ifid.pc;
  assign id_pc8      = w_ifid.pc8;
  assign id_valid    = w_ifid.valid;
  assign id_exc_code = w_ifid.excCode;
  assign fetch_cnt   = r_fetchCnt;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios then random traffic, all checked
// against a cycle-level reference model of the fetch rules.
module tb_if_fetch_unit;

  localparam logic [31:0] PC_BASE = 32'h0000_3000;
  localparam logic [31:0] PC_TOP  = 32'h0000_6FFF;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        flush;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] im_instr;
  logic [31:0] im_addr;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc8;
  logic        id_valid;
  logic [4:0]  id_exc_code;
  logic [31:0] fetch_cnt;

  int nCompared   = 0;
  int nMismatched = 0;

  // Reference state
  logic [31:0] mPc;
  logic [31:0] mInstr;
  logic [31:0] mIdPc;
  logic [31:0] mIdPc8;
  logic        mValid;
  logic [4:0]  mExc;
  logic [31:0] mCnt;

  if_fetch_unit dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .flush       (flush),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .im_instr    (im_instr),
    .im_addr     (im_addr),
    .id_instr    (id_instr),
    .id_pc       (id_pc),
    .id_pc8      (id_pc8),
    .id_valid    (id_valid),
    .id_exc_code (id_exc_code),
    .fetch_cnt   (fetch_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Instruction memory contents are a fixed scramble of the address
  function automatic logic [31:0] memWord(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
  endfunction

  assign im_instr = memWord(im_addr);

  function automatic logic fetchFaults(input logic [31:0] a);
`ifdef FETCH_EXC_EN
    return (a % 4 != 0) || (a < PC_BASE) || (a > PC_TOP);
`else
    return 1'b0;
`endif
  endfunction

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    assert (obs === exp)
    else begin
      nMismatched++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string step);
    checkVal({step, ".im_addr"},  im_addr,            mPc);
    checkVal({step, ".id_instr"}, id_instr,           mInstr);
    checkVal({step, ".id_pc"},    id_pc,              mIdPc);
    checkVal({step, ".id_pc8"},   id_pc8,             mIdPc8);
    checkVal({step, ".id_valid"}, {31'h0, id_valid},  {31'h0, mValid});
    checkVal({step, ".id_exc"},   {27'h0, id_exc_code}, {27'h0, mExc});
    checkVal({step, ".cnt"},      fetch_cnt,          mCnt);
  endtask

  // One clock: drive inputs, advance the model by the fetch rules, then compare
  task automatic applyStimulus(input string step, input logic rst, input logic st,
                               input logic fl, input logic rd, input logic [31:0] rpc);
    logic bad;
    reset       = rst;
    stall       = st;
    flush       = fl;
    redirect    = rd;
    redirect_pc = rpc;
    @(posedge clk);
    if (rst) begin
      mPc = PC_BASE; mInstr = 0; mIdPc = 0; mIdPc8 = 0; mValid = 0; mExc = 0; mCnt = 0;
    end else begin
      bad = fetchFaults(mPc);
      if (fl) begin
        mInstr = 0; mIdPc = 0; mIdPc8 = 0; mValid = 0; mExc = 0;
      end else if (!st) begin
        mInstr = bad ? 32'h0 : memWord(mPc);
        mIdPc  = mPc;
        mIdPc8 = mPc + 32'd8;
        mValid = 1'b1;
        mExc   = bad ? 5'd4 : 5'd0;
        mCnt   = mCnt + 32'd1;
      end
      if (!st) mPc = rd ? rpc : mPc + 32'd4;
    end
    #1;
    checkOutput(step);
  endtask

  initial begin
    reset = 1'b1; stall = 0; flush = 0; redirect = 0; redirect_pc = 0;
    mPc = 0; mInstr = 0; mIdPc = 0; mIdPc8 = 0; mValid = 0; mExc = 0; mCnt = 0;

    applyStimulus("rst0", 1, 0, 0, 0, 0);
    applyStimulus("rst1", 1, 0, 0, 0, 0);
    checkVal("rst.pc_const", im_addr, 32'h0000_3000);

    for (int i = 0; i < 3; i++) applyStimulus("seq", 0, 0, 0, 0, 0);
    checkVal("seq.pc_const", im_addr, 32'h0000_300C);
    checkVal("seq.idpc_const", id_pc, 32'h0000_3008);

    applyStimulus("redir", 0, 0, 0, 1, 32'h0000_3100);
    checkVal("redir.delay_slot", id_pc, 32'h0000_300C);
    checkVal("redir.target", im_addr, 32'h0000_3100);
    applyStimulus("redir_next", 0, 0, 0, 0, 0);
    checkVal("redir.next", im_addr, 32'h0000_3104);

    applyStimulus("toStall", 0, 0, 0, 1, 32'h0000_3010);
    for (int i = 0; i < 3; i++) applyStimulus("stall", 0, 1, 0, 1, 32'h0000_3400);
    checkVal("stall.pc_held", im_addr, 32'h0000_3010);
    applyStimulus("release", 0, 0, 0, 0, 0);
    checkVal("release.idpc", id_pc, 32'h0000_3010);

    applyStimulus("flushStall", 0, 1, 1, 0, 0);
    applyStimulus("flushRedir", 0, 0, 1, 1, 32'h0000_3200);
    checkVal("flush.target", im_addr, 32'h0000_3200);
    applyStimulus("afterFlush", 0, 0, 0, 0, 0);

    applyStimulus("toOdd", 0, 0, 0, 1, 32'h0000_3002);
    applyStimulus("oddFetch", 0, 0, 0, 1, 32'h0000_7000);
    applyStimulus("highFetch", 0, 0, 0, 0, 0);
    applyStimulus("wrapSet", 0, 0, 0, 1, 32'hFFFF_FFFC);
    applyStimulus("wrap0", 0, 0, 0, 0, 0);
    applyStimulus("wrap1", 0, 0, 0, 0, 0);
`ifdef FETCH_EXC_EN
    checkVal("exc.code_wrap", {27'h0, id_exc_code}, 32'd4);
`else
    checkVal("exc.code_none", {27'h0, id_exc_code}, 32'd0);
`endif

    for (int i = 0; i < 300; i++) begin
      logic [31:0] tgt;
      tgt = ($urandom_range(0, 3) != 0) ? PC_BASE + 4 * $urandom_range(0, 4095) : $urandom;
      applyStimulus("rand", $urandom_range(0, 49) == 0, $urandom_range(0, 3) == 0,
                    $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0, tgt);
    end

    applyStimulus("preRst", 0, 1, 0, 1, 32'h0000_3500);
    applyStimulus("midRst", 1, 1, 0, 1, 32'h0000_3500);
    checkVal("midRst.pc", im_addr, 32'h0000_3000);
    checkVal("midRst.cnt", fetch_cnt, 32'd0);
    checkVal("midRst.valid", {31'h0, id_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
